// File: rtl/brch_pkg.sv
// Shared definitions for the branch resolution controller: FSM state
// encoding, 2-bit predictor counter encodings and the saturating update rule.
package brch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } brch_state_e;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Every counter comes out of reset weakly not-taken.
    localparam logic [1:0] CNT_RESET = WNT;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == ST) ? ST : cnt + 2'd1;
        end else begin
            nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/brch_resolve_ctrl_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational lookup port and one synchronous update port. The lookup
// reads the stored value, so a same-index update in the same cycle is not
// visible until the next cycle.
module brch_bht
    import brch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] cnt_r [ENTRIES];

    assign rd_cnt = cnt_r[rd_idx];

    // Reset every counter to weakly not-taken, otherwise train the updated entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_r[i] <= CNT_RESET;
            end
        end else if (upd_en) begin
            cnt_r[upd_idx] <= cnt_next(cnt_r[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/brch_resolve_ctrl.sv
// Branch resolution and recovery controller. Predicts decode-stage branches,
// checks the execute-stage outcome and sequences RUN -> FLUSH -> DRAIN on a
// mispredict. Macro BRCH_PREDICT_EN enables the 2-bit BHT predictor; when it
// is undefined the block predicts static not-taken and holds no counters.
module brch_resolve_ctrl
    import brch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int PC_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_is_brch,
    input  logic [PC_W-1:0] id_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic            ex_is_brch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            ex_brch_cnd,
    input  logic [PC_W-1:0] ex_target,
    input  logic [PC_W-1:0] ex_pc_plus2,
    input  logic            ex_stall,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic [15:0]     mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    brch_state_e     state_r;
    logic            redirect_r;
    logic [PC_W-1:0] redirect_pc_r;
    logic            flush_if_id_r;
    logic            flush_id_ex_r;
    logic [15:0]     mispred_cnt_r;

    logic            resolve_s;
    logic            mispred_s;
    logic            unused_s;

    // Only a live, unstalled branch seen in RUN resolves; FLUSH/DRAIN ignore execute.
    assign resolve_s = (state_r == RUN) && ex_valid && ex_is_brch && !ex_stall;
    assign mispred_s = resolve_s && (ex_brch_cnd != ex_pred_taken);

    // PC bits outside the table index (and all PCs in the static build) are not needed.
    assign unused_s = ^{id_is_brch, id_pc, ex_pc};

`ifdef BRCH_PREDICT_EN
    logic [1:0] rd_cnt_s;

    brch_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (id_pc[IDX_W:1]),
        .rd_cnt    (rd_cnt_s),
        .upd_en    (resolve_s),
        .upd_idx   (ex_pc[IDX_W:1]),
        .upd_taken (ex_brch_cnd)
    );

    assign pred_taken = id_is_brch & rd_cnt_s[1];
`else
    assign pred_taken = 1'b0;
`endif

    // Recovery FSM with registered redirect/flush outputs and the mispredict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            redirect_r    <= 1'b0;
            redirect_pc_r <= {PC_W{1'b0}};
            flush_if_id_r <= 1'b0;
            flush_id_ex_r <= 1'b0;
            mispred_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (mispred_s) begin
                        state_r       <= FLUSH;
                        redirect_r    <= 1'b1;
                        flush_if_id_r <= 1'b1;
                        flush_id_ex_r <= 1'b1;
                        redirect_pc_r <= ex_brch_cnd ? ex_target : ex_pc_plus2;
                        if (mispred_cnt_r != 16'hFFFF) begin
                            mispred_cnt_r <= mispred_cnt_r + 16'd1;
                        end
                    end else begin
                        state_r       <= RUN;
                        redirect_r    <= 1'b0;
                        flush_if_id_r <= 1'b0;
                        flush_id_ex_r <= 1'b0;
                    end
                end
                FLUSH: begin
                    state_r       <= DRAIN;
                    redirect_r    <= 1'b0;
                    flush_if_id_r <= 1'b0;
                    flush_id_ex_r <= 1'b0;
                end
                DRAIN: begin
                    state_r       <= RUN;
                    redirect_r    <= 1'b0;
                    flush_if_id_r <= 1'b0;
                    flush_id_ex_r <= 1'b0;
                end
                default: begin
                    state_r       <= RUN;
                    redirect_r    <= 1'b0;
                    flush_if_id_r <= 1'b0;
                    flush_id_ex_r <= 1'b0;
                end
            endcase
        end
    end

    assign redirect    = redirect_r;
    assign redirect_pc = redirect_pc_r;
    assign flush_if_id = flush_if_id_r;
    assign flush_id_ex = flush_id_ex_r;
    assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_brch_resolve_ctrl.sv
// Self-checking bench for brch_resolve_ctrl. Expected redirect PCs go into a
// scoreboard queue when a mispredicting branch is driven and are popped when
// the FLUSH cycle appears. A bench-side BHT model tracks predictions when
// BRCH_PREDICT_EN is defined; otherwise prediction is static not-taken.
module tb_brch_resolve_ctrl;

    logic        clk;
    logic        rst;
    logic        id_is_brch;
    logic [15:0] id_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_brch;
    logic [15:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_brch_cnd;
    logic [15:0] ex_target;
    logic [15:0] ex_pc_plus2;
    logic        ex_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [15:0] mispred_cnt;

    brch_resolve_ctrl #(.BHT_ENTRIES(16), .PC_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_is_brch(id_is_brch), .id_pc(id_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_is_brch(ex_is_brch), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_brch_cnd(ex_brch_cnd),
        .ex_target(ex_target), .ex_pc_plus2(ex_pc_plus2), .ex_stall(ex_stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_cnt;
    logic [15:0] exp_pc;
    logic        last_mis;
    logic [15:0] pend_pc;
    logic        pend_cnd;

`ifdef BRCH_PREDICT_EN
    logic [1:0] m_bht [16];
`endif

    function automatic logic m_pred(input logic [15:0] pc);
`ifdef BRCH_PREDICT_EN
        return m_bht[pc[4:1]][1];
`else
        return pc[0] & 1'b0;
`endif
    endfunction

    task automatic m_reset();
`ifdef BRCH_PREDICT_EN
        for (int i = 0; i < 16; i++) m_bht[i] = 2'd1;
`endif
    endtask

    task automatic m_update(input logic [15:0] pc, input logic cnd);
`ifdef BRCH_PREDICT_EN
        if (cnd && m_bht[pc[4:1]] != 2'd3) m_bht[pc[4:1]] = m_bht[pc[4:1]] + 2'd1;
        else if (!cnd && m_bht[pc[4:1]] != 2'd0) m_bht[pc[4:1]] = m_bht[pc[4:1]] - 2'd1;
`else
        pend_pc = pc ^ {15'd0, cnd};
`endif
    endtask

    task automatic idle();
        id_is_brch = 1'b0; id_pc = 16'd0;
        ex_valid = 1'b0; ex_is_brch = 1'b0; ex_pc = 16'd0;
        ex_pred_taken = 1'b0; ex_brch_cnd = 1'b0;
        ex_target = 16'd0; ex_pc_plus2 = 16'd0; ex_stall = 1'b0;
    endtask

    // Drive a resolving branch (decode looks up the same PC); queue expectations.
    task automatic drive_br(input logic [15:0] pc, input logic cnd, input logic [15:0] tgt);
        id_is_brch = 1'b1; id_pc = pc;
        ex_valid = 1'b1; ex_is_brch = 1'b1; ex_pc = pc;
        ex_pred_taken = m_pred(pc); ex_brch_cnd = cnd;
        ex_target = tgt; ex_pc_plus2 = pc + 16'd2; ex_stall = 1'b0;
        last_mis = (cnd != ex_pred_taken);
        if (last_mis) begin
            sb.push_back(cnd ? tgt : pc + 16'd2);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        pend_pc = pc; pend_cnd = cnd;
    endtask

    task automatic step_br();
        @(posedge clk);
        m_update(pend_pc, pend_cnd);
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        id_is_brch = 1'b1; id_pc = 16'h0010;
        #1;
        n_checks++; if (pred_taken !== 1'b0) $display("FAIL rst_pred got %0b exp 0", pred_taken); else n_pass++;
        n_checks++; if ({redirect, flush_if_id, flush_id_ex} !== 3'b000) $display("FAIL rst_flush got %b exp 000", {redirect, flush_if_id, flush_id_ex}); else n_pass++;
        n_checks++; if (redirect_pc !== 16'd0) $display("FAIL rst_rpc got %h exp 0000", redirect_pc); else n_pass++;
        n_checks++; if (mispred_cnt !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", mispred_cnt); else n_pass++;
        rst = 1'b0; idle();
        @(negedge clk);
    endtask

    task automatic test_mispredict();
        drive_br(16'h0010, 1'b1, 16'h0040);
        step_br();
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        n_checks++; if ({redirect, flush_if_id, flush_id_ex} !== 3'b111) $display("FAIL mp_flush got %b exp 111", {redirect, flush_if_id, flush_id_ex}); else n_pass++;
        n_checks++; if (redirect_pc !== exp_pc) $display("FAIL mp_rpc got %h exp %h", redirect_pc, exp_pc); else n_pass++;
        n_checks++; if (mispred_cnt !== exp_cnt) $display("FAIL mp_cnt got %0d exp %0d", mispred_cnt, exp_cnt); else n_pass++;
        @(negedge clk);
        n_checks++; if ({redirect, flush_if_id, flush_id_ex} !== 3'b000) $display("FAIL mp_drain got %b exp 000", {redirect, flush_if_id, flush_id_ex}); else n_pass++;
        // A mispredicting branch presented during DRAIN must be ignored.
        ex_valid = 1'b1; ex_is_brch = 1'b1; ex_pc = 16'h0020;
        ex_pred_taken = 1'b0; ex_brch_cnd = 1'b1; ex_target = 16'h0aaa;
        @(negedge clk);
        idle();
        n_checks++; if (redirect !== 1'b0) $display("FAIL drain_ignore got %0b exp 0", redirect); else n_pass++;
        n_checks++; if (mispred_cnt !== exp_cnt) $display("FAIL drain_cnt got %0d exp %0d", mispred_cnt, exp_cnt); else n_pass++;
        @(negedge clk);
    endtask

    // Train one PC through a table of outcomes, following recovery when needed.
    task automatic run_seq(input logic [15:0] pc, input logic [7:0] cnds, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive_br(pc, cnds[i], pc + 16'h0100);
            #1;
            n_checks++; if (pred_taken !== ex_pred_taken) $display("FAIL %s_pred[%0d] got %0b exp %0b", tag, i, pred_taken, ex_pred_taken); else n_pass++;
            step_br();
            if (last_mis) begin
                exp_pc = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
                n_checks++; if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL %s_redir[%0d] got %0b/%h exp 1/%h", tag, i, redirect, redirect_pc, exp_pc); else n_pass++;
                @(negedge clk);
                @(negedge clk);
            end else begin
                n_checks++; if (redirect !== 1'b0) $display("FAIL %s_noredir[%0d] got %0b exp 0", tag, i, redirect); else n_pass++;
            end
        end
        id_is_brch = 1'b1; id_pc = pc;
        #1;
        n_checks++; if (pred_taken !== m_pred(pc)) $display("FAIL %s_final got %0b exp %0b", tag, pred_taken, m_pred(pc)); else n_pass++;
        n_checks++; if (mispred_cnt !== exp_cnt) $display("FAIL %s_cnt got %0d exp %0d", tag, mispred_cnt, exp_cnt); else n_pass++;
        idle();
        @(negedge clk);
    endtask

    task automatic test_training();
        // bit i is outcome i: taken, then five not-taken, then two taken
        run_seq(16'h0010, 8'b1100_0001, 8, "train");
    endtask

    task automatic test_stall();
        drive_br(16'h0030, 1'b1, 16'h0300);
        ex_stall = 1'b1;
        sb.delete();
        if (last_mis) exp_cnt = exp_cnt - 16'd1;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (redirect !== 1'b0) $display("FAIL stall_hold got %0b exp 0", redirect); else n_pass++;
        end
        drive_br(16'h0030, 1'b1, 16'h0300);
        step_br();
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL stall_release got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else n_pass++;
        ex_stall = 1'b1; ex_valid = 1'b1; ex_is_brch = 1'b1; ex_brch_cnd = 1'b1;
        @(negedge clk);
        n_checks++; if ({redirect, flush_if_id, flush_id_ex} !== 3'b000) $display("FAIL stall_drain got %b exp 000", {redirect, flush_if_id, flush_id_ex}); else n_pass++;
        @(negedge clk);
        idle();
        drive_br(16'h0050, 1'b1, 16'h0500);
        step_br();
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL stall_run got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else n_pass++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_in_flush();
        drive_br(16'h0060, 1'b1, 16'h0600);
        step_br();
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL rf_flush got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete(); exp_cnt = 16'd0; m_reset();
        n_checks++; if ({redirect, flush_if_id, flush_id_ex} !== 3'b000 || redirect_pc !== 16'd0 || mispred_cnt !== 16'd0) $display("FAIL rf_outs got %b/%h/%0d exp 000/0000/0", {redirect, flush_if_id, flush_id_ex}, redirect_pc, mispred_cnt); else n_pass++;
        id_is_brch = 1'b1; id_pc = 16'h0010;
        #1;
        n_checks++; if (pred_taken !== 1'b0) $display("FAIL rf_bht got %0b exp 0", pred_taken); else n_pass++;
        drive_br(16'h0010, 1'b1, 16'h0090);
        step_br();
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== exp_pc || mispred_cnt !== exp_cnt) $display("FAIL rf_run got %0b/%h/%0d exp 1/%h/%0d", redirect, redirect_pc, mispred_cnt, exp_pc, exp_cnt); else n_pass++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_non_branch();
        ex_valid = 1'b1; ex_is_brch = 1'b0; ex_pc = 16'h0070;
        ex_pred_taken = 1'b0; ex_brch_cnd = 1'b1; ex_target = 16'h0777;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_brch = 1'b1;
        @(negedge clk);
        idle();
        n_checks++; if (redirect !== 1'b0 || mispred_cnt !== exp_cnt) $display("FAIL nonbr got %0b/%0d exp 0/%0d", redirect, mispred_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_seq(16'h007a, 8'b0000_1111, 4, "b2b");
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.mispred_cnt_r = 16'hFFFF;
        @(negedge clk);
        release dut.mispred_cnt_r;
        exp_cnt = 16'hFFFF;
        drive_br(16'h0084, 1'b1, 16'h0800);
        step_br();
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== exp_pc) $display("FAIL sat_redir got %0b/%h exp 1/%h", redirect, redirect_pc, exp_pc); else n_pass++;
        n_checks++; if (mispred_cnt !== 16'hFFFF) $display("FAIL sat_cnt got %h exp ffff", mispred_cnt); else n_pass++;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; exp_cnt = 16'd0; last_mis = 1'b0;
        pend_pc = 16'd0; pend_cnd = 1'b0; exp_pc = 16'd0;
        idle(); m_reset();
        test_reset();
        test_mispredict();
        test_training();
        test_stall();
        test_reset_in_flush();
        test_non_branch();
        test_back_to_back();
        test_saturation();
        n_checks++; if (sb.size() != 0) $display("FAIL sb_empty got %0d exp 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
